// File: rtl/ccd_pkg.sv
// Shared types for the CCD capture path: FSM states, FIFO entry layout and
// default geometry widths.
package ccd_pkg;

  localparam int CCD_DATA_MAX     = 16;
  localparam int CCD_ACTIVE_PIX   = 640;
  localparam int CCD_ACTIVE_LINES = 480;
  localparam int CCD_FIFO_DEPTH   = 16;

  localparam int CCD_PIX_W  = $clog2(CCD_ACTIVE_PIX + 1);
  localparam int CCD_LINE_W = $clog2(CCD_ACTIVE_LINES + 1);
  localparam int CCD_FIFO_AW = $clog2(CCD_FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LINE,
    ST_SKIP,
    ST_CAPTURE,
    ST_LINE_END
  } ccd_state_t;

  // Data field sized for the widest supported ADC; narrower ADCs zero-fill.
  typedef struct packed {
    logic                    sof;
    logic                    eol;
    logic [CCD_DATA_MAX-1:0] data;
  } ccd_fifo_entry_t;

  function automatic int ccd_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccd_pix_fifo.sv
// Show-ahead pixel FIFO: head is visible combinationally whenever not empty.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module ccd_pix_fifo
  import ccd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  ccd_fifo_entry_t push_ent,
  input  logic            pop,
  output ccd_fifo_entry_t head,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);

  ccd_fifo_entry_t mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            wr_ok, rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok = pop & ~empty;
  assign wr_ok = push & (~full | rd_ok);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= push_ent;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ccd_pixel_capture.sv
// CCD receive-side capture: windows the AFE sample stream using delayed hblank
// and emits pixels with sof/eol via ccd_pix_fifo. CCD_TEST_PATTERN_EN swaps
// adc_data for a position-derived ramp.
module ccd_pixel_capture
  import ccd_pkg::*;
#(
  parameter int ADC_W        = 12,
  parameter int ADC_LAT      = 3,
  parameter int SKIP_PIX     = 8,
  parameter int ACTIVE_PIX   = CCD_ACTIVE_PIX,
  parameter int SKIP_LINES   = 4,
  parameter int ACTIVE_LINES = CCD_ACTIVE_LINES,
  parameter int FIFO_DEPTH   = CCD_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             hblank,
  input  logic [ADC_W-1:0] adc_data,
  output logic [ADC_W-1:0] pix_data,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             overflow,
  output logic             short_line,
  output logic             busy
);

  localparam int CW        = ccd_cnt_w((SKIP_PIX > ACTIVE_PIX) ? SKIP_PIX : ACTIVE_PIX);
  localparam int LW        = ccd_cnt_w(SKIP_LINES + ACTIVE_LINES);
  localparam int LAST_LINE = SKIP_LINES + ACTIVE_LINES - 1;

  ccd_state_t      state, state_nx;
  logic [ADC_LAT:0] hb_pipe;
  logic            hb_d, hb_fall;
  logic [CW-1:0]   pix_cnt, pix_cnt_nx;
  logic [LW-1:0]   line_cnt;
  logic            cap, line_done, set_short, wr_en;
  logic            hold_vld, sof_pend;
  logic [ADC_W-1:0] hold_data, sample;
  logic            push, pop, full, empty;
  ccd_fifo_entry_t push_ent, head;

  // Extra tap beyond the delayed hblank gives the previous hb_d for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hb_pipe <= '1;
    else        hb_pipe <= {hb_pipe[ADC_LAT-1:0], hblank};
  end

  assign hb_d    = hb_pipe[ADC_LAT-1];
  assign hb_fall = hb_pipe[ADC_LAT] & ~hb_d;
  assign wr_en   = (int'(line_cnt) >= SKIP_LINES);

`ifdef CCD_TEST_PATTERN_EN
  logic unused_adc;
  assign unused_adc = ^adc_data;
  assign sample = ADC_W'((int'(line_cnt) - SKIP_LINES) * ACTIVE_PIX + int'(pix_cnt));
`else
  assign sample = adc_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      pix_cnt <= '0;
    end else begin
      state   <= state_nx;
      pix_cnt <= pix_cnt_nx;
    end
  end

  // pix_cnt counts dropped samples in SKIP and captured samples in CAPTURE.
  always_comb begin
    state_nx   = state;
    pix_cnt_nx = pix_cnt;
    cap        = 1'b0;
    line_done  = 1'b0;
    set_short  = 1'b0;
    if (frame_start) begin
      state_nx   = ST_WAIT_LINE;
      pix_cnt_nx = '0;
    end else begin
      case (state)
        ST_WAIT_LINE: begin
          if (hb_fall) begin
            if (SKIP_PIX == 0) begin
              cap        = 1'b1;
              pix_cnt_nx = CW'(1);
              state_nx   = (ACTIVE_PIX == 1) ? ST_LINE_END : ST_CAPTURE;
            end else if (SKIP_PIX == 1) begin
              pix_cnt_nx = '0;
              state_nx   = ST_CAPTURE;
            end else begin
              pix_cnt_nx = CW'(1);
              state_nx   = ST_SKIP;
            end
          end
        end
        ST_SKIP: begin
          if (hb_d) begin
            set_short = 1'b1;
            state_nx  = ST_LINE_END;
          end else if (pix_cnt == CW'(SKIP_PIX - 1)) begin
            pix_cnt_nx = '0;
            state_nx   = ST_CAPTURE;
          end else begin
            pix_cnt_nx = pix_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (hb_d) begin
            set_short = 1'b1;
            state_nx  = ST_LINE_END;
          end else begin
            cap        = 1'b1;
            pix_cnt_nx = pix_cnt + 1'b1;
            if (pix_cnt == CW'(ACTIVE_PIX - 1)) state_nx = ST_LINE_END;
          end
        end
        ST_LINE_END: begin
          line_done  = 1'b1;
          pix_cnt_nx = '0;
          state_nx   = (line_cnt == LW'(LAST_LINE)) ? ST_IDLE : ST_WAIT_LINE;
        end
        default: ;
      endcase
    end
  end

  // The held sample is only known to be a line's last once the line ends,
  // so every pixel is pushed one sample late.
  assign push = hold_vld & ((cap & wr_en) | line_done);
  assign pop  = pix_ready & ~empty;

  always_comb begin
    push_ent                  = '0;
    push_ent.sof              = sof_pend;
    push_ent.eol              = line_done;
    push_ent.data[ADC_W-1:0]  = hold_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_cnt   <= '0;
      hold_vld   <= 1'b0;
      hold_data  <= '0;
      sof_pend   <= 1'b0;
      overflow   <= 1'b0;
      short_line <= 1'b0;
    end else if (frame_start) begin
      line_cnt   <= '0;
      hold_vld   <= 1'b0;
      sof_pend   <= 1'b1;
      overflow   <= 1'b0;
      short_line <= 1'b0;
    end else begin
      if (push) sof_pend <= 1'b0;
      if (cap && wr_en) begin
        hold_data <= sample;
        hold_vld  <= 1'b1;
      end
      if (line_done) begin
        hold_vld <= 1'b0;
        line_cnt <= line_cnt + 1'b1;
      end
      if (set_short) short_line <= 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  ccd_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_ent (push_ent),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  generate
    if (ADC_W < CCD_DATA_MAX) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^head.data[CCD_DATA_MAX-1:ADC_W];
    end
  endgenerate

  assign pix_valid = ~empty;
  assign pix_data  = empty ? '0 : head.data[ADC_W-1:0];
  assign pix_sof   = ~empty & head.sof;
  assign pix_eol   = ~empty & head.eol;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ccd_pixel_capture.sv
// Scoreboard bench for ccd_pixel_capture: random line lengths, samples and
// backpressure against a line-level reference model.
module tb_ccd_pixel_capture;

  localparam int ADC_W = 12, ADC_LAT = 3, SKIP_PIX = 2, ACTIVE_PIX = 4;
  localparam int SKIP_LINES = 1, ACTIVE_LINES = 3, FIFO_DEPTH = 4;
  localparam int FULL_L = SKIP_PIX + ACTIVE_PIX;
  localparam int RM_RAND = 0, RM_HOLD = 1, RM_ON = 2;

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic [ADC_W-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             frame_start = 1'b0;
  logic             hblank = 1'b1;
  logic [ADC_W-1:0] adc_data = '0;
  logic [ADC_W-1:0] pix_data;
  logic             pix_sof, pix_eol, pix_valid;
  logic             pix_ready = 1'b0;
  logic             overflow, short_line, busy;

  int   checks = 0, errors = 0;
  int   ready_mode = RM_ON;
  exp_t exp_q[$];
  logic [ADC_W-1:0] samp [64];

  // Reference model state (frame/line level)
  bit m_active, m_sof, m_short, m_ovf;
  int m_line, m_room;

  ccd_pixel_capture #(
    .ADC_W(ADC_W), .ADC_LAT(ADC_LAT), .SKIP_PIX(SKIP_PIX), .ACTIVE_PIX(ACTIVE_PIX),
    .SKIP_LINES(SKIP_LINES), .ACTIVE_LINES(ACTIVE_LINES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .hblank(hblank),
    .adc_data(adc_data), .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .overflow(overflow),
    .short_line(short_line), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: picks this cycle's ready and checks any transfer it will cause.
  logic mon_r;
  exp_t mon_e;
  always @(negedge clk) begin
    case (ready_mode)
      RM_RAND: mon_r = ($urandom_range(3) != 0);
      RM_HOLD: mon_r = 1'b0;
      default: mon_r = 1'b1;
    endcase
    pix_ready = mon_r;
    if (reset && pix_valid && mon_r) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel got %0h want none", {pix_sof, pix_eol, pix_data});
      end else begin
        mon_e = exp_q.pop_front();
        chk("pixel", 32'({pix_sof, pix_eol, pix_data}), 32'(mon_e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADC_W-1:0] val(input int k);
`ifdef CCD_TEST_PATTERN_EN
    int v;
    v = (m_line - SKIP_LINES) * ACTIVE_PIX + (k - SKIP_PIX);
    return v[ADC_W-1:0];
`else
    return samp[k];
`endif
  endfunction

  task automatic mpush(input bit eol, input logic [ADC_W-1:0] d);
    exp_t e;
    e.sof = m_sof;
    e.eol = eol;
    e.data = d;
    m_sof = 0;
    if (ready_mode == RM_HOLD) begin
      if (m_room == 0) begin
        m_ovf = 1;
        return;
      end
      m_room--;
    end
    exp_q.push_back(e);
  endtask

  task automatic model_new_frame();
    m_active = 1; m_line = 0; m_sof = 1; m_short = 0; m_ovf = 0;
  endtask

  // A line with L samples of hb_d low: samples SKIP_PIX..FULL_L-1 are active;
  // an abort at sample k keeps everything captured before k except the held one.
  task automatic model_line(input int L, input int abort_k);
    int hi;
    if (!m_active) return;
    hi = (L < FULL_L) ? L : FULL_L;
    if (abort_k >= 0) begin
      if (abort_k < hi) hi = abort_k;
      if (m_line >= SKIP_LINES)
        for (int k = SKIP_PIX; k < hi - 1; k++) mpush(1'b0, val(k));
      model_new_frame();
    end else begin
      if (m_line >= SKIP_LINES)
        for (int k = SKIP_PIX; k < hi; k++) mpush(k == hi - 1, val(k));
      if (L < FULL_L) m_short = 1;
      m_line++;
      if (m_line == SKIP_LINES + ACTIVE_LINES) m_active = 0;
    end
  endtask

  task automatic start_frame();
    hblank = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    model_new_frame();
    repeat (6) tick();
  endtask

  task automatic drive_line(input int L, input int B, input int abort_c);
    for (int k = 0; k < L; k++) samp[k] = ADC_W'($urandom);
    model_line(L, (abort_c >= 0) ? abort_c - ADC_LAT : -1);
    for (int c = 0; c < L + B; c++) begin
      hblank = (c < L) ? 1'b0 : 1'b1;
      adc_data = (c >= ADC_LAT && c - ADC_LAT < L) ? samp[c - ADC_LAT] : ADC_W'($urandom);
      frame_start = (c == abort_c);
      tick();
    end
    frame_start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    hblank = 1'b1;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    repeat (8) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic frame_end_checks();
    chk("busy_idle", busy, 0);
    chk("short_line", short_line, m_short);
    chk("overflow", overflow, m_ovf);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_valid", pix_valid, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_sof", pix_sof, 0);
    chk("rst_eol", pix_eol, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_short", short_line, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) tick();

    // Nominal frame, always ready
    ready_mode = RM_ON;
    start_frame();
    chk("busy_frame", busy, 1);
    for (int l = 0; l < SKIP_LINES + ACTIVE_LINES; l++) drive_line(FULL_L, 8, -1);
    drain();
    frame_end_checks();

    // Short active line: 3 pixels, last with eol
    start_frame();
    drive_line(FULL_L, 8, -1);
    drive_line(FULL_L - 1, 8, -1);
    drive_line(FULL_L, 8, -1);
    drive_line(FULL_L, 8, -1);
    drain();
    frame_end_checks();

    // Random frames: line lengths, samples and backpressure
    ready_mode = RM_RAND;
    for (int f = 0; f < 6; f++) begin
      start_frame();
      for (int l = 0; l < SKIP_LINES + ACTIVE_LINES; l++) begin
        drive_line($urandom_range(1, FULL_L + 3), $urandom_range(6, 12), -1);
        drain();
      end
      frame_end_checks();
    end

    // Backpressure: second active line lands on a full FIFO
    ready_mode = RM_ON;
    start_frame();
    drive_line(FULL_L, 8, -1);
    ready_mode = RM_HOLD;
    m_room = FIFO_DEPTH;
    drive_line(FULL_L, 8, -1);
    drive_line(FULL_L, 8, -1);
    chk("ovf_set", overflow, m_ovf);
    chk("ovf_valid", pix_valid, 1);
    ready_mode = RM_ON;
    drain();
    drive_line(FULL_L, 8, -1);
    drain();
    frame_end_checks();
    start_frame();
    chk("ovf_cleared", overflow, 0);
    for (int l = 0; l < SKIP_LINES + ACTIVE_LINES; l++) drive_line(FULL_L, 8, -1);
    drain();
    frame_end_checks();

    // Mid-frame restart during the second active line
    ready_mode = RM_RAND;
    start_frame();
    drive_line(FULL_L, 8, -1);
    drive_line(FULL_L, 10, -1);
    drain();
    drive_line(FULL_L, 10, ADC_LAT + 4);
    chk("busy_after_abort", busy, 1);
    drain();
    for (int l = 0; l < SKIP_LINES + ACTIVE_LINES; l++) begin
      drive_line($urandom_range(FULL_L - 1, FULL_L + 2), 10, -1);
      drain();
    end
    frame_end_checks();

    // Async reset mid-capture with pixels queued
    ready_mode = RM_HOLD;
    start_frame();
    drive_line(FULL_L, 8, -1);
    m_active = 0;
    hblank = 1'b0;
    for (int c = 0; c < ADC_LAT + 5; c++) begin
      adc_data = ADC_W'($urandom);
      tick();
    end
    chk("pre_reset_valid", pix_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("reset_valid", pix_valid, 0);
    chk("reset_busy", busy, 0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    hblank = 1'b1;
    ready_mode = RM_RAND;
    repeat (8) tick();
    drive_line(FULL_L, 8, -1);
    drive_line(FULL_L, 8, -1);
    drain();
    chk("no_out_valid", pix_valid, 0);
    chk("no_out_busy", busy, 0);

    // Recovery frame after reset
    start_frame();
    for (int l = 0; l < SKIP_LINES + ACTIVE_LINES; l++) begin
      drive_line(FULL_L, 10, -1);
      drain();
    end
    frame_end_checks();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccd_pixel_capture.md
Name: ccd_pixel_capture

Overview:
Receive-side counterpart of the ICX CCD timing generator. Samples the analog front-end ADC output in lock-step with the H1/H2 pixel clocks it drives. Uses the timing generator's hblank and a frame-start strobe to drop dummy/optical-black pixels and lines. Emits an active-window pixel stream with start-of-frame/end-of-line markers through a small elastic FIFO toward the frame buffer/USB side.

Parameters:
ADC_W, 12, ADC sample width
ADC_LAT, 3, clk cycles from pixel clock edge to valid ADC sample (pipeline delay of AFE)
SKIP_PIX, 8, dummy/OB pixels discarded at the start of each line
ACTIVE_PIX, 640, pixels captured per line
SKIP_LINES, 4, lines discarded after frame start
ACTIVE_LINES, 480, lines captured per frame
FIFO_DEPTH, 16, output FIFO entries (power of 2, >=4)

Ports:
clk  in  1  pixel-rate clock (same DCM output as timing generator)
reset  in  1  asynchronous, active-low reset
frame_start  in  1  one-cycle strobe from timing generator at start of readout (after last vertical transfer)
hblank  in  1  timing generator horizontal blank, 1 = H clocks gated
adc_data  in  ADC_W  AFE sample, valid every clk
pix_data  out  ADC_W  output pixel
pix_sof  out  1  marks first pixel of frame
pix_eol  out  1  marks last pixel of line
pix_valid  out  1  output handshake
pix_ready  in  1  output handshake; transfer when valid & ready
overflow  out  1  sticky: pixel dropped on full FIFO
short_line  out  1  sticky: hblank rose before ACTIVE_PIX captured
busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters 0, FIFO empty, pix_valid/pix_sof/pix_eol/overflow/short_line/busy 0, pix_data 0.
- hblank delayed ADC_LAT cycles through shift register (reset 1) -> hb_d; all capture decisions use hb_d so data and blanking align.
- States: IDLE -> (frame_start) WAIT_LINE -> (hb_d falls) SKIP -> (SKIP_PIX samples dropped) CAPTURE -> (ACTIVE_PIX captured or hb_d rises) LINE_END -> WAIT_LINE, or IDLE after ACTIVE_LINES captured lines.
- SKIP_PIX=0: hb_d fall enters CAPTURE directly; first sample in that same cycle is captured.
- Line counter counts every hb_d fall after frame_start. Lines 0..SKIP_LINES-1: SKIP/CAPTURE run but nothing written.
- Capture: one-entry holding register. Each new sample pushes the previous held sample into FIFO. On line end, held sample is pushed with eol=1. sof=1 on first pushed pixel of the frame only.
- Samples after ACTIVE_PIX in a line are ignored until next hb_d fall.
- hb_d rises in SKIP or mid-CAPTURE: set short_line. If >=1 pixel held, it is emitted with eol. Line still counts toward ACTIVE_LINES.
- frame_start while not IDLE: abort current frame, discard holding register (FIFO contents kept), restart line count, clear overflow and short_line, go WAIT_LINE. frame_start in IDLE also clears both stickies.
- FIFO: {sof,eol,data}, FIFO_DEPTH entries, show-ahead; pix_* driven from head. Push and pop same cycle when full is legal (no drop). Push when full and no pop: pixel dropped, overflow set. A dropped eol pixel loses its eol marker.
- Throughput 1 pixel/clk in; the hblank interval is expected to drain the FIFO.
- busy=0 only in IDLE; the frame completes to IDLE after the final eol push even if FIFO not yet drained.

Optional Feature:
CCD_TEST_PATTERN_EN
- Defined: adc_data ignored. Captured value = (line_index_in_active_window*ACTIVE_PIX + pixel_index) truncated to ADC_W bits, inserted at the same pipeline point. All timing, skip, overflow and short_line behaviour is unchanged.
- Undefined: adc_data captured. No pattern logic present.

Decomposition:
- Package ccd_pkg: capture state enum, FIFO entry struct {sof,eol,data}, localparam widths from $clog2 of ACTIVE_PIX/ACTIVE_LINES/FIFO_DEPTH.
- One sub-module: ccd_pix_fifo. Synchronous show-ahead FIFO with push/pop/full/empty, same clk/reset.

Test Plan:
- Nominal frame, ACTIVE_PIX=4, SKIP_PIX=2, SKIP_LINES=1, ACTIVE_LINES=2, ADC ramp, pix_ready=1 -> 8 pixels out. First has sof. Pixels 4 and 8 have eol. Values equal ramp at offsets 2..5 of lines 1,2 after ADC_LAT alignment. busy returns to 0.
- Backpressure: pix_ready=0 for whole line with ACTIVE_PIX=20, FIFO_DEPTH=16 -> 16 entries held, overflow=1, pixels 17..20 lost. Next frame_start clears overflow.
- Short line: hblank rises after 3 captured pixels (ACTIVE_PIX=4) -> 3 pixels out, third has eol, short_line=1.
- Mid-frame frame_start during line 2 of 4 -> holding register discarded. Next emitted pixel carries sof. Line count restarts.
- Async reset asserted mid-CAPTURE with FIFO non-empty -> pix_valid=0 immediately, busy=0. No output until new frame_start.
- With CCD_TEST_PATTERN_EN, ACTIVE_PIX=4: second active line outputs 4,5,6,7 regardless of adc_data.
